// File: rtl/click_if.sv
// Button-event and click-classification signals between the debouncer side and the decoder.
interface click_if;
    logic i_pulse;
    logic o_single;
    logic o_double;
    logic o_triple;
    logic o_busy;

    modport master (
        output i_pulse,
        input  o_single,
        input  o_double,
        input  o_triple,
        input  o_busy
    );

    modport slave (
        input  i_pulse,
        output o_single,
        output o_double,
        output o_triple,
        output o_busy
    );
endinterface

// File: rtl/click_decoder.sv
// Groups button events inside a sliding window and emits one single/double(/triple) pulse per group.
// Optional triple-click detection is enabled by defining CLICK_TRIPLE_EN.
module click_decoder #(
    parameter int CNT_WIDTH = 24,
    parameter int WINDOW    = 10000000
) (
    input  logic   clk,
    input  logic   i_rst_n,
    click_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] TIMER_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] TIMER_ONE  = CNT_WIDTH'(1);

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CNT_WIDTH-1:0]   timer_r;
    logic [CNT_WIDTH-1:0]   timer_nx_s;
    logic                   pulse_d_r;
    logic                   ev_s;
    logic                   single_r;
    logic                   single_nx_s;
    logic                   double_r;
    logic                   double_nx_s;
`ifdef CLICK_TRIPLE_EN
    logic                   triple_r;
    logic                   triple_nx_s;
`endif

    // A held-high level yields only one event: its rising edge.
    assign ev_s = bus.i_pulse & ~pulse_d_r;

    // Next-state, timer and classification decode.
    always_comb begin
        state_nx_s  = state_r;
        timer_nx_s  = timer_r;
        single_nx_s = 1'b0;
        double_nx_s = 1'b0;
`ifdef CLICK_TRIPLE_EN
        triple_nx_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                timer_nx_s = TIMER_ZERO;
                if (ev_s) begin
                    state_nx_s = WAIT1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT1: begin
                // A click coinciding with the timeout wins over the timeout.
                if (ev_s) begin
                    timer_nx_s = TIMER_ZERO;
`ifdef CLICK_TRIPLE_EN
                    state_nx_s = WAIT2;
`else
                    state_nx_s  = IDLE;
                    double_nx_s = 1'b1;
`endif
                end else if (timer_r == TIMER_LAST) begin
                    timer_nx_s  = TIMER_ZERO;
                    state_nx_s  = IDLE;
                    single_nx_s = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TIMER_ONE;
                end
            end
            WAIT2: begin
`ifdef CLICK_TRIPLE_EN
                if (ev_s) begin
                    timer_nx_s  = TIMER_ZERO;
                    state_nx_s  = IDLE;
                    triple_nx_s = 1'b1;
                end else if (timer_r == TIMER_LAST) begin
                    timer_nx_s  = TIMER_ZERO;
                    state_nx_s  = IDLE;
                    double_nx_s = 1'b1;
                end else begin
                    timer_nx_s = timer_r + TIMER_ONE;
                end
`else
                timer_nx_s = TIMER_ZERO;
                state_nx_s = IDLE;
`endif
            end
            default: begin
                timer_nx_s = TIMER_ZERO;
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, timer, edge detector and registered classification outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            timer_r   <= TIMER_ZERO;
            pulse_d_r <= 1'b0;
            single_r  <= 1'b0;
            double_r  <= 1'b0;
`ifdef CLICK_TRIPLE_EN
            triple_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            pulse_d_r <= bus.i_pulse;
            single_r  <= single_nx_s;
            double_r  <= double_nx_s;
`ifdef CLICK_TRIPLE_EN
            triple_r  <= triple_nx_s;
`endif
        end
    end

    assign bus.o_single = single_r;
    assign bus.o_double = double_r;
`ifdef CLICK_TRIPLE_EN
    assign bus.o_triple = triple_r;
`else
    assign bus.o_triple = 1'b0;
`endif
    assign bus.o_busy   = (state_r != IDLE);

endmodule

// File: tb/tb_click_decoder.sv
// Randomized and directed check of click_decoder against a click-timestamp reference model.
module tb_click_decoder;
    localparam int CW  = 4;
    localparam int WIN = 8;
`ifdef CLICK_TRIPLE_EN
    localparam int MAXC = 3;
`else
    localparam int MAXC = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    click_if bus();

    click_decoder #(.CNT_WIDTH(CW), .WINDOW(WIN)) dut (
        .clk    (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   t           = 0;
    logic prev_p      = 1'b0;
    int   clicks[$];
    logic exp_s = 1'b0, exp_d = 1'b0, exp_t = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, t, got, exp);
        end
    endtask

    // Close the open group: its click count selects the classification.
    task close_group;
        exp_s = (clicks.size() == 1);
        exp_d = (clicks.size() == 2);
        exp_t = (clicks.size() == 3);
        clicks.delete();
    endtask

    // Reference: group = list of click times; closes at MAXC clicks or WIN edges after the last click.
    task model_step(input logic p, input logic r);
        logic ev;
        t++;
        exp_s = 1'b0; exp_d = 1'b0; exp_t = 1'b0;
        if (!r) begin
            prev_p = 1'b0;
            clicks.delete();
        end else begin
            ev     = p && !prev_p;
            prev_p = p;
            if (ev) begin
                clicks.push_back(t);
                if (clicks.size() == MAXC) close_group();
            end else if (clicks.size() > 0 && (t - clicks[$]) == WIN) begin
                close_group();
            end
        end
    endtask

    task tick(input logic p, input logic r);
        bus.i_pulse = p;
        rst_n       = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        check_eq("single", {31'd0, bus.o_single}, {31'd0, exp_s});
        check_eq("double", {31'd0, bus.o_double}, {31'd0, exp_d});
        check_eq("triple", {31'd0, bus.o_triple}, {31'd0, exp_t});
        check_eq("busy",   {31'd0, bus.o_busy},   {31'd0, (clicks.size() > 0)});
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
    endtask

    task pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b1);
            if (i != n - 1) idle(gap - 1);
        end
    endtask

    initial begin
        int lat;
        int density;
        int len;
        bus.i_pulse = 1'b0;
        rst_n       = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        idle(2);

        // Lone click: single pulse WIN+1 cycles after the click edge.
        tick(1'b1, 1'b1);
        lat = 0;
        for (int i = 1; i <= 3 * WIN; i++) begin
            tick(1'b0, 1'b1);
            if (bus.o_single === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        check_eq("single_latency", lat, WIN + 1);
        idle(5);

        pulses(2, 4);           idle(3 * WIN);
        pulses(3, 4);           idle(3 * WIN);
        pulses(2, WIN);         idle(3 * WIN);
        pulses(3, WIN);         idle(3 * WIN);
        pulses(4, 2);           idle(3 * WIN);

        // Held level counts once.
        for (int i = 0; i < 21; i++) tick(1'b1, 1'b1);
        idle(3 * WIN);
        pulses(1, 1);           idle(3 * WIN);

        // Reset mid-group clears outputs at once and drops the group.
        tick(1'b1, 1'b1);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy",   {31'd0, bus.o_busy},   32'd0);
        check_eq("rst_single", {31'd0, bus.o_single}, 32'd0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        idle(4);
        pulses(1, 1);           idle(3 * WIN);

        // Randomized segments with varying click density and occasional reset.
        for (int s = 0; s < 30; s++) begin
            density = $urandom_range(5, 60);
            len     = $urandom_range(50, 150);
            for (int i = 0; i < len; i++) begin
                tick(($urandom_range(0, 99) < density) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0);
            end
        end
        idle(3 * WIN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/click_decoder.md
Name: click_decoder

Overview:
Downstream consumer of the debounced one-cycle button pulse stream. Groups consecutive button events that fall inside a programmable time window and emits one classification pulse per group: single click, double click, and optionally triple click. The mode/menu control logic uses these outputs in place of raw button events.

Parameters:
CNT_WIDTH, 24, width of the window timer; must hold WINDOW-1.
WINDOW, 10000000, window length in clk cycles, measured from the last accepted click (200 ms at 50 MHz); legal range 2 .. 2**CNT_WIDTH.

Ports:
clk  input  1  system clock; all state on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_pulse  input  1  debounced button event; nominally one cycle wide.
o_single  output  1  one-cycle pulse: group closed with 1 click.
o_double  output  1  one-cycle pulse: group closed with 2 clicks.
o_triple  output  1  one-cycle pulse: group closed with 3 clicks (see Optional Feature).
o_busy  output  1  high while a group is open (state != IDLE).

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE, timer=0, edge register=0, all outputs 0. Releasing reset in the middle of a group discards that group; no output is emitted for it.
- Click event: ev = i_pulse & ~i_pulse_d, where i_pulse_d is i_pulse registered.
- A level held high for N cycles counts as one click. A new click requires a low cycle first.
- All outputs are registered. Each classification pulse is high for exactly one cycle. At most one of o_single/o_double/o_triple is high in any cycle.
- States: IDLE, WAIT1 (1 click seen), WAIT2 (2 clicks seen; used only with the macro).
- IDLE:
  - ev -> WAIT1, timer := 0.
  - Otherwise the timer holds at 0.
- WAIT1:
  - ev -> without the macro: o_double=1 next cycle, go to IDLE. With the macro: go to WAIT2, timer := 0.
  - No ev and timer==WINDOW-1 -> o_single=1 next cycle, go to IDLE.
  - Otherwise timer += 1.
- WAIT2:
  - ev -> o_triple=1 next cycle, go to IDLE.
  - No ev and timer==WINDOW-1 -> o_double=1 next cycle, go to IDLE.
  - Otherwise timer += 1.
- Latency:
  - Closing click at edge k -> output high during cycle k+1.
  - Single click at edge k -> o_single high during cycle k+WINDOW+1.
- Simultaneous events:
  - An ev in the same cycle as timeout counts as a click; no timeout output is emitted.
  - An ev in IDLE in the same cycle a classification output is high opens a new group normally, with no lost click.
- Timer never wraps: it only counts in WAIT1/WAIT2 and is cleared on every state exit.
- o_busy is combinational from the state register: 1 in WAIT1/WAIT2.

Optional Feature:
CLICK_TRIPLE_EN
- Defined: WAIT2 exists and triple clicks are detected as described above. Double-click output is delayed until the window after the second click expires.
- Undefined: no WAIT2. The second click emits o_double immediately (next cycle). o_triple is tied to 0, and a third click starts a new group.

Test Plan:
1. WINDOW=8, one 1-cycle pulse at cycle 10 -> o_busy high cycles 11..18; o_single high only at cycle 19; o_double and o_triple stay 0.
2. WINDOW=8, no macro, pulses at cycles 10 and 14 -> o_double high at cycle 15, o_busy low from cycle 15; no o_single.
3. WINDOW=8, CLICK_TRIPLE_EN, pulses at cycles 10, 14, 18 -> o_triple at cycle 19. Pulses at 10 and 14 only -> o_double at cycle 23.
4. WINDOW=8, pulse at 10, second pulse exactly at timeout cycle 18 -> treated as a click: o_double (no macro) at 19, no o_single.
5. i_pulse held high for cycles 10..30 -> counted as one click: o_single at cycle 19; no further outputs until i_pulse drops and rises again.
6. Pulse at 10, i_rst_n low at cycle 13 for 2 cycles -> all outputs 0 immediately; no output for the aborted group; a fresh pulse at 20 yields o_single at 29.
